uart_tx_engine: RTL and testbench

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls one word per frame from an upstream FIFO and
// serialises it as start bit, DATA_WIDTH data bits (LSB first), optional
// parity bit and one or two stop bits, each BAUD_DIV clocks long.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY bit after DATA.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_DIV   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  stop2,
    input  logic                  parity_odd,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int CNT_W  = $clog2(DATA_WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BAUD_DIV - 2);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [BAUD_W-1:0]     baud_cnt_r;
    logic [CNT_W-1:0]      bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_next_s;
    logic                  stop2_r;
    logic                  tx_r;
    logic                  tx_busy_r;
    logic                  tx_done_r;
    logic                  tx_next_s;
    logic                  fifo_rd_en_s;
    logic                  bit_end_s;
    logic                  stop_last_s;
    logic                  par_bit_s;

`ifdef UART_TX_PARITY_EN
    logic                  par_bit_r;

    // Even parity of a data word (1 when the word holds an odd number of ones).
    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    // Parity is computed once when the word is fetched, with the sense latched then.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit_r <= 1'b0;
        end else if (state_r == FETCH) begin
            par_bit_r <= parity_of(fifo_rdata) ^ parity_odd;
        end else begin
            par_bit_r <= par_bit_r;
        end
    end

    assign par_bit_s = par_bit_r;
`else
    logic unused_parity_s;
    assign unused_parity_s = parity_odd;
    assign par_bit_s       = 1'b1;
`endif

    assign bit_end_s   = (baud_cnt_r == BAUD_LAST);
    assign stop_last_s = (bit_cnt_r == {{(CNT_W-1){1'b0}}, stop2_r});
    // A read is never requested while reset is held.
    assign fifo_rd_en  = fifo_rd_en_s & ~rst;
    assign tx          = tx_r;
    assign tx_busy     = tx_busy_r;
    assign tx_done     = tx_done_r;

    // Next-state, FIFO read request, next shift value and next line level.
    always_comb begin
        state_next_s = state_r;
        fifo_rd_en_s = 1'b0;
        shift_next_s = shift_r;
        tx_next_s    = 1'b1;
        case (state_r)
            IDLE: begin
                if (tx_en && !fifo_empty) begin
                    fifo_rd_en_s = 1'b1;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH:   state_next_s = START;
            START: begin
                if (bit_end_s) state_next_s = DATA;
                else           state_next_s = START;
            end
            DATA: begin
                if (bit_end_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) state_next_s = STOP;
                else           state_next_s = PARITY;
            end
            STOP: begin
                if (bit_end_s && stop_last_s) state_next_s = IDLE;
                else                          state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase

        if (state_r == FETCH) begin
            shift_next_s = fifo_rdata;
        end else if ((state_r == DATA) && bit_end_s) begin
            shift_next_s = shift_r >> 1;
        end else begin
            shift_next_s = shift_r;
        end

        case (state_next_s)
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_next_s[0];
            PARITY:  tx_next_s = par_bit_s;
            default: tx_next_s = 1'b1;
        endcase
    end

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= {BAUD_W{1'b0}};
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {DATA_WIDTH{1'b0}};
            stop2_r    <= 1'b0;
            tx_r       <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_next_s;
            tx_busy_r <= (state_next_s != IDLE);
            // Registered one cycle early so the pulse lands on the final stop cycle.
            tx_done_r <= (state_r == STOP) && stop_last_s && (baud_cnt_r == BAUD_PRE);

            if ((state_r == IDLE) || (state_r == FETCH) || bit_end_s) begin
                baud_cnt_r <= {BAUD_W{1'b0}};
            end else begin
                baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
            end

            case (state_r)
                IDLE, FETCH: bit_cnt_r <= {CNT_W{1'b0}};
                DATA: begin
                    if (bit_end_s && (bit_cnt_r == BIT_LAST)) bit_cnt_r <= {CNT_W{1'b0}};
                    else if (bit_end_s)                       bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    else                                      bit_cnt_r <= bit_cnt_r;
                end
                STOP: begin
                    if (bit_end_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                    else           bit_cnt_r <= bit_cnt_r;
                end
                default: bit_cnt_r <= bit_cnt_r;
            endcase

            if (state_r == FETCH) stop2_r <= stop2;
            else                  stop2_r <= stop2_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine (BAUD_DIV=4, DATA_WIDTH=8).
// Expected waveforms are built from the frame definition: a list of line
// bits per frame, each held BAUD cycles, with FIFO-read/fetch spacing.
module tb_uart_tx_engine;

    localparam int BAUD = 4;
    localparam int MAXC = 512;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       stop2 = 1'b0;
    logic       parity_odd = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    uart_tx_engine #(.DATA_WIDTH(8), .BAUD_DIV(BAUD)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .stop2(stop2),
        .parity_odd(parity_odd), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(fifo_rd_en),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data appears the cycle after an accepted read.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + 8'd1;
        end
    end

    int checks = 0;
    int failures = 0;
    logic [7:0] frm_q[$];
    logic exp_tx [MAXC], exp_busy [MAXC], exp_done [MAXC], exp_rd [MAXC];
    logic act_tx [MAXC], act_busy [MAXC], act_done [MAXC], act_rd [MAXC];
    int exp_len;
    int fd_tx, fd_busy, fd_done, fd_rd;

    task automatic queue_byte(input logic [7:0] b, input bit in_frames);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
        if (in_frames) frm_q.push_back(b);
    endtask

    // Expected trace: first read at cycle 0, frames back to back, idle from cut on.
    function automatic void build(input logic s2, input logic po, input int cut);
        int t;
        logic bits[$];
        for (int c = 0; c < MAXC; c++) begin
            exp_tx[c] = 1'b1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_rd[c] = 1'b0;
        end
        t = 0;
        for (int f = 0; f < frm_q.size(); f++) begin
            bits = {};
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(frm_q[f][i]);
            if (PB == 1) bits.push_back((^frm_q[f]) ^ po);
            bits.push_back(1'b1);
            if (s2) bits.push_back(1'b1);
            exp_rd[t] = 1'b1;
            exp_busy[t+1] = 1'b1;
            for (int k = 0; k < bits.size(); k++) begin
                for (int j = 0; j < BAUD; j++) begin
                    exp_tx[t+2+k*BAUD+j]   = bits[k];
                    exp_busy[t+2+k*BAUD+j] = 1'b1;
                end
            end
            exp_done[t+1+bits.size()*BAUD] = 1'b1;
            t = t + 2 + bits.size() * BAUD;
        end
        exp_len = t;
        if (cut >= 0) begin
            for (int c = cut; c < MAXC; c++) begin
                exp_tx[c] = 1'b1; exp_busy[c] = 1'b0; exp_done[c] = 1'b0; exp_rd[c] = 1'b0;
            end
        end
    endfunction

    // Record n cycles (sampled 1 time unit after each falling edge) and note first divergences.
    // act_kind: 1 = one-cycle reset pulse, 2 = drop tx_en, 3 = toggle stop2/parity_odd.
    task automatic capture(input int n, input int act_c, input int act_kind);
        fd_tx = -1; fd_busy = -1; fd_done = -1; fd_rd = -1;
        for (int c = 0; c < n; c++) begin
            if (c == act_c) begin
                case (act_kind)
                    1: rst = 1'b1;
                    2: tx_en = 1'b0;
                    3: begin stop2 = ~stop2; parity_odd = ~parity_odd; end
                    default: ;
                endcase
            end
            if ((act_kind == 1) && (c == act_c + 1)) rst = 1'b0;
            #1;
            act_tx[c] = tx; act_busy[c] = tx_busy; act_done[c] = tx_done; act_rd[c] = fifo_rd_en;
            if ((fd_tx < 0) && (tx !== exp_tx[c])) fd_tx = c;
            if ((fd_busy < 0) && (tx_busy !== exp_busy[c])) fd_busy = c;
            if ((fd_done < 0) && (tx_done !== exp_done[c])) fd_done = c;
            if ((fd_rd < 0) && (fifo_rd_en !== exp_rd[c])) fd_rd = c;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        tx_en = 1'b1;
        frm_q = {};
        queue_byte(8'h5A, 1'b1);
        #1;
        checks++; if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", tx); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", tx_done); end
        @(negedge clk);
        rst = 1'b0;
        build(1'b0, 1'b0, -1);
        capture(exp_len + 3, -1, 0);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL post_reset_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_rd >= 0) begin failures++; $display("FAIL post_reset_rd cycle=%0d got=%b exp=%b", fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
    endtask

    task automatic test_basic();
        int rd_cnt, first_low, done_at;
        stop2 = 1'b0; parity_odd = 1'b0;
        frm_q = {};
        queue_byte(8'hA5, 1'b1);
        build(1'b0, 1'b0, -1);
        capture(exp_len + 3, -1, 0);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL basic_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_busy >= 0) begin failures++; $display("FAIL basic_busy cycle=%0d got=%b exp=%b", fd_busy, act_busy[fd_busy], exp_busy[fd_busy]); end
        checks++; if (fd_done >= 0) begin failures++; $display("FAIL basic_done cycle=%0d got=%b exp=%b", fd_done, act_done[fd_done], exp_done[fd_done]); end
        checks++; if (fd_rd >= 0) begin failures++; $display("FAIL basic_rd cycle=%0d got=%b exp=%b", fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
        rd_cnt = 0; first_low = -1; done_at = -1;
        for (int c = 0; c < exp_len + 3; c++) begin
            if (act_rd[c]) rd_cnt++;
            if ((first_low < 0) && !act_tx[c]) first_low = c;
            if ((done_at < 0) && act_done[c]) done_at = c;
        end
        checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL basic_rd_count got=%0d exp=1", rd_cnt); end
        checks++; if (first_low !== 2) begin failures++; $display("FAIL basic_start_latency got=%0d exp=2", first_low); end
        checks++; if (done_at !== 1 + 40 + 4 * PB) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_at, 1 + 40 + 4 * PB); end
    endtask

    task automatic test_parity();
        int done_at;
        for (int p = 0; p < 2; p++) begin
            parity_odd = p[0];
            frm_q = {};
            queue_byte(8'h07, 1'b1);
            build(1'b0, p[0], -1);
            capture(exp_len + 3, -1, 0);
            checks++; if (fd_tx >= 0) begin failures++; $display("FAIL parity_tx odd=%0d cycle=%0d got=%b exp=%b", p, fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
            checks++; if (fd_done >= 0) begin failures++; $display("FAIL parity_done odd=%0d cycle=%0d got=%b exp=%b", p, fd_done, act_done[fd_done], exp_done[fd_done]); end
            done_at = -1;
            for (int c = 0; c < exp_len + 3; c++) if ((done_at < 0) && act_done[c]) done_at = c;
`ifdef UART_TX_PARITY_EN
            checks++; if (act_tx[39] !== ~p[0]) begin failures++; $display("FAIL parity_bit odd=%0d got=%b exp=%b", p, act_tx[39], ~p[0]); end
            checks++; if (done_at !== 45) begin failures++; $display("FAIL parity_frame_len odd=%0d got=%0d exp=45", p, done_at); end
`else
            checks++; if (done_at !== 41) begin failures++; $display("FAIL noparity_frame_len odd=%0d got=%0d exp=41", p, done_at); end
`endif
        end
        parity_odd = 1'b0;
    endtask

    task automatic test_stop2();
        int done_at;
        stop2 = 1'b1; parity_odd = 1'b0;
        frm_q = {};
        queue_byte(8'hFF, 1'b1);
        build(1'b1, 1'b0, -1);
        capture(exp_len + 3, 20, 3);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL stop2_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_done >= 0) begin failures++; $display("FAIL stop2_done cycle=%0d got=%b exp=%b", fd_done, act_done[fd_done], exp_done[fd_done]); end
        done_at = -1;
        for (int c = 0; c < exp_len + 3; c++) if ((done_at < 0) && act_done[c]) done_at = c;
        checks++; if (done_at !== 45 + 4 * PB) begin failures++; $display("FAIL stop2_done_cycle got=%0d exp=%0d", done_at, 45 + 4 * PB); end
        stop2 = 1'b0; parity_odd = 1'b0;
    endtask

    task automatic test_back_to_back();
        int rd_cnt;
        frm_q = {};
        queue_byte(8'h11, 1'b1);
        queue_byte(8'h22, 1'b1);
        queue_byte(8'h33, 1'b1);
        build(1'b0, 1'b0, -1);
        capture(exp_len + 4, -1, 0);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL b2b_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_busy >= 0) begin failures++; $display("FAIL b2b_busy cycle=%0d got=%b exp=%b", fd_busy, act_busy[fd_busy], exp_busy[fd_busy]); end
        checks++; if (fd_done >= 0) begin failures++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", fd_done, act_done[fd_done], exp_done[fd_done]); end
        checks++; if (fd_rd >= 0) begin failures++; $display("FAIL b2b_rd cycle=%0d got=%b exp=%b", fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
        rd_cnt = 0;
        for (int c = 0; c < exp_len + 4; c++) if (act_rd[c]) rd_cnt++;
        checks++; if (rd_cnt !== 3) begin failures++; $display("FAIL b2b_rd_count got=%0d exp=3", rd_cnt); end
    endtask

    task automatic test_midframe_reset();
        int rd_cnt;
        frm_q = {};
        queue_byte(8'($urandom_range(0, 255)), 1'b1);
        build(1'b0, 1'b0, 20);
        capture(50, 19, 1);
        checks++; if (act_tx[20] !== 1'b1) begin failures++; $display("FAIL rst_tx got=%b exp=1", act_tx[20]); end
        checks++; if (act_busy[20] !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", act_busy[20]); end
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL rst_trace_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_done >= 0) begin failures++; $display("FAIL rst_trace_done cycle=%0d got=%b exp=%b", fd_done, act_done[fd_done], exp_done[fd_done]); end
        rd_cnt = 0;
        for (int c = 0; c < 50; c++) if (act_rd[c]) rd_cnt++;
        checks++; if (rd_cnt !== 1) begin failures++; $display("FAIL rst_rd_count got=%0d exp=1", rd_cnt); end
    endtask

    task automatic test_txen_drop();
        frm_q = {};
        queue_byte(8'h3C, 1'b1);
        queue_byte(8'h55, 1'b0);
        build(1'b0, 1'b0, -1);
        capture(exp_len + 8, 3, 2);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL txen_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_done >= 0) begin failures++; $display("FAIL txen_done cycle=%0d got=%b exp=%b", fd_done, act_done[fd_done], exp_done[fd_done]); end
        checks++; if (fd_rd >= 0) begin failures++; $display("FAIL txen_rd cycle=%0d got=%b exp=%b", fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
        tx_en = 1'b1;
        frm_q = {};
        frm_q.push_back(8'h55);
        build(1'b0, 1'b0, -1);
        capture(exp_len + 3, -1, 0);
        checks++; if (fd_tx >= 0) begin failures++; $display("FAIL txen_resume_tx cycle=%0d got=%b exp=%b", fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
        checks++; if (fd_rd >= 0) begin failures++; $display("FAIL txen_resume_rd cycle=%0d got=%b exp=%b", fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
    endtask

    task automatic test_random();
        logic s2, po;
        for (int it = 0; it < 2; it++) begin
            s2 = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            stop2 = s2; parity_odd = po;
            frm_q = {};
            for (int i = 0; i < 4; i++) queue_byte(8'($urandom_range(0, 255)), 1'b1);
            build(s2, po, -1);
            capture(exp_len + 4, -1, 0);
            checks++; if (fd_tx >= 0) begin failures++; $display("FAIL rand%0d_tx cycle=%0d got=%b exp=%b", it, fd_tx, act_tx[fd_tx], exp_tx[fd_tx]); end
            checks++; if (fd_busy >= 0) begin failures++; $display("FAIL rand%0d_busy cycle=%0d got=%b exp=%b", it, fd_busy, act_busy[fd_busy], exp_busy[fd_busy]); end
            checks++; if (fd_done >= 0) begin failures++; $display("FAIL rand%0d_done cycle=%0d got=%b exp=%b", it, fd_done, act_done[fd_done], exp_done[fd_done]); end
            checks++; if (fd_rd >= 0) begin failures++; $display("FAIL rand%0d_rd cycle=%0d got=%b exp=%b", it, fd_rd, act_rd[fd_rd], exp_rd[fd_rd]); end
        end
        stop2 = 1'b0; parity_odd = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_midframe_reset();
        test_txen_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
